conv_1x1_sched: RTL and testbench



---
 rtl/conv_1x1_sched_pkg.sv | 38 +++
 rtl/conv_1x1_sched_cnt.sv | 29 ++
 rtl/conv_1x1_sched.sv | 134 +++++++++++++
 tb/tb_conv_1x1_sched.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/conv_1x1_sched_pkg.sv
// Shared types, default geometry and width helpers for the 1x1 convolution sequencer.
package conv_1x1_sched_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    WAIT_W = 3'd2,
    STREAM = 3'd3,
    DRAIN  = 3'd4,
    DONE   = 3'd5
  } state_t;

  // Ceiling log2, never below 1 so degenerate sizes still give a usable width.
  function automatic int clog2(input int value);
    int res;
    res = 1;
    for (int i = 1; i < 31; i++) begin
      if ((32'sd1 << i) < value) begin
        res = i + 1;
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  localparam int DEF_IMAGE_WIDTH     = 32;
  localparam int DEF_IMAGE_HEIGHT    = 32;
  localparam int DEF_CHANNEL_NUM_IN  = 128;
  localparam int DEF_CHANNEL_NUM_OUT = 256;
  localparam int DEF_DATA_WIDTH      = 32;

  localparam int IMAGE_SIZE = DEF_IMAGE_WIDTH * DEF_IMAGE_HEIGHT;
  localparam int PX_AW      = clog2(IMAGE_SIZE * DEF_CHANNEL_NUM_IN);
  localparam int W_AW       = clog2(DEF_CHANNEL_NUM_IN * DEF_CHANNEL_NUM_OUT);
  localparam int CO_W       = clog2(DEF_CHANNEL_NUM_OUT);

endpackage

// File: rtl/conv_1x1_sched_cnt.sv
// Wrap counter: counts up on inc, returns to zero after max and flags the carry.
module conv_1x1_sched_cnt
  import conv_1x1_sched_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] max,
  output logic [W-1:0] count,
  output logic         wrap
);

  assign wrap = inc && (count == max);

  // Count register; wrap feeds the next counter in the chain as its increment.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= {W{1'b0}};
    end else if (inc) begin
      count <= wrap ? {W{1'b0}} : count + W'(1);
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/conv_1x1_sched.sv
// Layer sequencer: per (co, ci) pair loads one weight, then streams the ci plane of pixels.
module conv_1x1_sched
  import conv_1x1_sched_pkg::*;
#(
  parameter  int IMAGE_WIDTH     = DEF_IMAGE_WIDTH,
  parameter  int IMAGE_HEIGHT    = DEF_IMAGE_HEIGHT,
  parameter  int CHANNEL_NUM_IN  = DEF_CHANNEL_NUM_IN,
  parameter  int CHANNEL_NUM_OUT = DEF_CHANNEL_NUM_OUT,
  parameter  int DATA_WIDTH      = DEF_DATA_WIDTH,
  localparam int IMG_SIZE        = IMAGE_WIDTH * IMAGE_HEIGHT,
  localparam int PX_ADDR_W       = clog2(IMG_SIZE * CHANNEL_NUM_IN),
  localparam int W_ADDR_W        = clog2(CHANNEL_NUM_IN * CHANNEL_NUM_OUT),
  localparam int CO_IDX_W        = clog2(CHANNEL_NUM_OUT)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stall,
  output logic                 px_rd_en,
  output logic [PX_ADDR_W-1:0] px_rd_addr,
  output logic                 w_rd_en,
  output logic [W_ADDR_W-1:0]  w_rd_addr,
  output logic                 valid_in,
  output logic                 valid_weight_in,
  output logic                 first_pass,
  output logic                 last_pass,
  output logic [CO_IDX_W-1:0]  ch_out_idx,
  output logic                 busy,
  output logic                 done
);

  localparam int PIX_W = clog2(IMG_SIZE);
  localparam int CI_W  = clog2(CHANNEL_NUM_IN);

  if (DATA_WIDTH < 1) begin : g_bad_data_width
    $error("DATA_WIDTH must be at least 1");
  end

  state_t state, state_next;

  logic                pix_inc, cnt_clr;
  logic                pix_wrap, ci_wrap, co_wrap;
  logic [PIX_W-1:0]    pix;
  logic [CI_W-1:0]     ci;
  logic [CO_IDX_W-1:0] co;

  // Pixel reads issue on every unstalled STREAM cycle; the counters only move on an issue.
  assign pix_inc  = (state == STREAM) && !stall;
  assign cnt_clr  = (state == IDLE) && start;
  assign px_rd_en = pix_inc;
  assign w_rd_en  = (state == LOAD_W);
  assign busy     = (state != IDLE);

  conv_1x1_sched_cnt #(.W(PIX_W)) u_pix_cnt (
    .clk(clk), .reset(reset), .clr(cnt_clr), .inc(pix_inc),
    .max(PIX_W'(IMG_SIZE - 1)), .count(pix), .wrap(pix_wrap)
  );

  conv_1x1_sched_cnt #(.W(CI_W)) u_ci_cnt (
    .clk(clk), .reset(reset), .clr(cnt_clr), .inc(pix_wrap),
    .max(CI_W'(CHANNEL_NUM_IN - 1)), .count(ci), .wrap(ci_wrap)
  );

  conv_1x1_sched_cnt #(.W(CO_IDX_W)) u_co_cnt (
    .clk(clk), .reset(reset), .clr(cnt_clr), .inc(ci_wrap),
    .max(CO_IDX_W'(CHANNEL_NUM_OUT - 1)), .count(co), .wrap(co_wrap)
  );

  // Addresses are forced to zero when the matching read enable is low.
  always_comb begin
    px_rd_addr = {PX_ADDR_W{1'b0}};
    w_rd_addr  = {W_ADDR_W{1'b0}};
    if (px_rd_en) begin
      px_rd_addr = PX_ADDR_W'(ci) * PX_ADDR_W'(IMG_SIZE) + PX_ADDR_W'(pix);
    end else begin
      px_rd_addr = {PX_ADDR_W{1'b0}};
    end
    if (w_rd_en) begin
      w_rd_addr = W_ADDR_W'(co) * W_ADDR_W'(CHANNEL_NUM_IN) + W_ADDR_W'(ci);
    end else begin
      w_rd_addr = {W_ADDR_W{1'b0}};
    end
  end

  // Next-state logic; a plane ends only on an issued (unstalled) last pixel.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = LOAD_W;
        end else begin
          state_next = IDLE;
        end
      end
      LOAD_W: state_next = WAIT_W;
      WAIT_W: state_next = STREAM;
      STREAM: begin
        if (co_wrap) begin
          state_next = DRAIN;
        end else if (pix_wrap) begin
          state_next = LOAD_W;
        end else begin
          state_next = STREAM;
        end
      end
      DRAIN:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register plus the one-cycle-delayed datapath strobes and accumulator flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      valid_in        <= 1'b0;
      valid_weight_in <= 1'b0;
      first_pass      <= 1'b0;
      last_pass       <= 1'b0;
      ch_out_idx      <= {CO_IDX_W{1'b0}};
      done            <= 1'b0;
    end else begin
      state           <= state_next;
      valid_in        <= px_rd_en;
      valid_weight_in <= w_rd_en;
      first_pass      <= px_rd_en && (ci == {CI_W{1'b0}});
      last_pass       <= px_rd_en && (ci == CI_W'(CHANNEL_NUM_IN - 1));
      ch_out_idx      <= px_rd_en ? co : {CO_IDX_W{1'b0}};
      done            <= (state == DONE);
    end
  end

endmodule

// File: tb/tb_conv_1x1_sched.sv
// Self-checking bench for conv_1x1_sched on a 2x2 image, 2 input and 2 output channels.
module tb_conv_1x1_sched;

  localparam int IW = 2, IH = 2, CI = 2, CO = 2, IS = IW * IH;
  localparam int PX_AW = 3, W_AW = 2, CO_W = 1;
  localparam int K_IDLE = 0, K_W = 1, K_G = 2, K_P = 3, K_DRAIN = 4, K_DONEST = 5, K_PULSE = 6;

  logic clk = 1'b0;
  logic reset, start, stall;
  logic px_rd_en, w_rd_en, valid_in, valid_weight_in, first_pass, last_pass, busy, done;
  logic [PX_AW-1:0] px_rd_addr;
  logic [W_AW-1:0]  w_rd_addr;
  logic [CO_W-1:0]  ch_out_idx;

  always #5 clk = ~clk;

  conv_1x1_sched #(
    .IMAGE_WIDTH(IW), .IMAGE_HEIGHT(IH), .CHANNEL_NUM_IN(CI),
    .CHANNEL_NUM_OUT(CO), .DATA_WIDTH(32)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .px_rd_en(px_rd_en), .px_rd_addr(px_rd_addr), .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr),
    .valid_in(valid_in), .valid_weight_in(valid_weight_in), .first_pass(first_pass),
    .last_pass(last_pass), .ch_out_idx(ch_out_idx), .busy(busy), .done(done)
  );

  typedef struct {
    int kind;
    int addr;
    bit fp;
    bit lp;
    int co;
    int seq;
  } slot_t;

  slot_t q[$];
  slot_t prev_slot;
  bit    prev_px, prev_w;
  int    checks = 0, fails = 0;
  int    vin_cnt, vw_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Timeline of the layer as the spec describes it: per (co, ci) a weight slot, a
  // wait slot and IS pixel slots, then drain, done state and the done pulse.
  task automatic build_model();
    slot_t s;
    int seq;
    q.delete();
    seq = 0;
    for (int o = 0; o < CO; o++) begin
      for (int c = 0; c < CI; c++) begin
        s = '{kind: K_W, addr: o * CI + c, fp: 1'b0, lp: 1'b0, co: o, seq: -1};
        q.push_back(s);
        s.kind = K_G;
        q.push_back(s);
        for (int p = 0; p < IS; p++) begin
          s = '{kind: K_P, addr: c * IS + p, fp: (c == 0), lp: (c == CI - 1), co: o, seq: seq};
          q.push_back(s);
          seq++;
        end
      end
    end
    s = '{kind: K_DRAIN, addr: 0, fp: 1'b0, lp: 1'b0, co: 0, seq: -1};
    q.push_back(s);
    s.kind = K_DONEST;
    q.push_back(s);
    s.kind = K_PULSE;
    q.push_back(s);
  endtask

  task automatic check_cycle(input bit stl);
    slot_t h;
    bit epx, ew, ebusy, edone;
    if (q.size() > 0) begin
      h = q[0];
    end else begin
      h = '{kind: K_IDLE, addr: 0, fp: 1'b0, lp: 1'b0, co: 0, seq: -1};
    end
    epx   = (h.kind == K_P) && !stl;
    ew    = (h.kind == K_W);
    ebusy = (h.kind >= K_W) && (h.kind <= K_DONEST);
    edone = (h.kind == K_PULSE);
    chk("px_rd_en", px_rd_en, epx);
    chk("w_rd_en", w_rd_en, ew);
    chk("busy", busy, ebusy);
    chk("done", done, edone);
    chk("valid_in", valid_in, prev_px);
    chk("valid_weight_in", valid_weight_in, prev_w);
    if (epx) chk("px_rd_addr", px_rd_addr, h.addr);
    if (ew) chk("w_rd_addr", w_rd_addr, h.addr);
    if (prev_px) begin
      chk("first_pass", first_pass, prev_slot.fp);
      chk("last_pass", last_pass, prev_slot.lp);
      chk("ch_out_idx", ch_out_idx, prev_slot.co);
    end
    if (valid_in === 1'b1) vin_cnt++;
    if (valid_weight_in === 1'b1) vw_cnt++;
    prev_px = epx;
    prev_w  = ew;
    if (epx) prev_slot = h;
  endtask

  // One layer: rnd selects random stalls; otherwise st_len stall cycles on pixel st_seq.
  task automatic run_layer(input bit rnd, input int st_seq, input int st_len,
                           input int s1, input int s2, input int rst_at);
    int n, rem, stall_p, done_at;
    bit stl, aborted;
    vin_cnt = 0;
    vw_cnt  = 0;
    @(posedge clk); #1;
    start = 1'b1; stall = 1'b0; reset = 1'b0;
    #1;
    check_cycle(1'b0);
    build_model();
    n = 0; rem = st_len; stall_p = 0; done_at = -1; aborted = 1'b0;
    while (q.size() > 0 && n < 200) begin
      @(posedge clk); #1;
      start = (n == s1) || (n == s2);
      reset = (n == rst_at);
      if (rnd) begin
        stl = ($urandom_range(0, 3) == 0);
      end else begin
        stl = (q[0].kind == K_P) && (q[0].seq == st_seq) && (rem > 0);
        if (stl) rem--;
      end
      stall = stl;
      #1;
      if (q[0].kind == K_P && stl) stall_p++;
      check_cycle(stl);
      if (done === 1'b1) done_at = n;
      if (!(q[0].kind == K_P && stl)) void'(q.pop_front());
      if (reset) begin
        aborted = 1'b1;
        break;
      end
      n++;
    end
    if (aborted) begin
      q.delete();
      prev_px = 1'b0;
      prev_w  = 1'b0;
      for (int k = 0; k < 4; k++) begin
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0; stall = 1'b0;
        #1;
        check_cycle(1'b0);
        chk("post_reset_first_pass", first_pass, 1'b0);
        chk("post_reset_last_pass", last_pass, 1'b0);
        chk("post_reset_ch_out_idx", ch_out_idx, 1'b0);
      end
    end else begin
      chk("layer_timeout", q.size(), 0);
      chk("done_cycle", done_at, 26 + stall_p);
      chk("valid_in_beats", vin_cnt, CI * CO * IS);
      chk("valid_weight_beats", vw_cnt, CI * CO);
    end
    start = 1'b0;
    stall = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stall = 1'b0;
    prev_px = 1'b0; prev_w = 1'b0;
    prev_slot = '{kind: K_IDLE, addr: 0, fp: 1'b0, lp: 1'b0, co: 0, seq: -1};
    repeat (2) @(posedge clk);
    #1;
    check_cycle(1'b0);
    chk("reset_first_pass", first_pass, 1'b0);
    chk("reset_last_pass", last_pass, 1'b0);
    chk("reset_ch_out_idx", ch_out_idx, 1'b0);
    // start together with reset must not launch a layer
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; reset = 1'b0;
    @(posedge clk); #1;
    check_cycle(1'b0);
    chk("reset_beats_start_busy", busy, 1'b0);

    run_layer(1'b0, -1, 0, -1, -1, -1);   // clean layer
    run_layer(1'b0, 2, 3, -1, -1, -1);    // 3-cycle stall at pixel address 2
    run_layer(1'b0, -1, 0, 5, 20, -1);    // start re-pulsed mid-layer
    run_layer(1'b0, -1, 0, -1, -1, 10);   // reset mid-STREAM
    run_layer(1'b0, -1, 0, -1, -1, -1);   // clean layer after abort
    run_layer(1'b0, 15, 1, -1, -1, -1);   // stall on the very last pixel
    for (int r = 0; r < 4; r++) begin
      run_layer(1'b1, -1, 0, -1, -1, -1); // random stalls
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
